// File: rtl/hex_count_source.sv
// Hex digit source: prescaled up/down counter with debounced pause/direction buttons.
// Single clock domain; the step rate comes from a clock-enable tick.
module hex_count_source #(
  parameter int DIV        = 25_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_dir,
  output logic [3:0] hex_out,
  output logic       dp_out,
  output logic       step_tick,
  output logic       count_up
);

  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  state_t        state;
  logic [1:0]    btn_raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    stable;
  logic [1:0]    press;
  logic [CW-1:0] deb_cnt [2];
  logic [PW-1:0] pre;
  logic          tick;
  logic          pause_press;
  logic          dir_press;

  // Bit 0 is pause, bit 1 is direction; both are active-low
  assign btn_raw     = {btn_dir, btn_pause};
  assign pause_press = press[0];
  assign dir_press   = press[1];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_a <= '1;
      sync_b <= '1;
      stable <= '1;
      press  <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      press  <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb_cnt[i] <= '0;
          stable[i]  <= sync_b[i];
          press[i]   <= ~sync_b[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign tick = (state == RUN) && (pre == PRE_MAX);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= RUN;
      dp_out    <= 1'b0;
      pre       <= '0;
      hex_out   <= 4'd0;
      step_tick <= 1'b0;
      count_up  <= 1'b1;
    end else begin
      step_tick <= tick;
      if (state == RUN) begin
        pre <= tick ? '0 : pre + PW'(1);
      end
      if (tick) begin
        hex_out <= count_up ? hex_out + 4'd1 : hex_out - 4'd1;
      end
      if (dir_press) begin
        count_up <= ~count_up;
      end
      if (pause_press) begin
        unique case (state)
          RUN: begin
            state  <= HOLD;
            dp_out <= 1'b1;
          end
          HOLD: begin
            state  <= RUN;
            dp_out <= 1'b0;
          end
          default: begin
            state  <= RUN;
            dp_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_count_source.sv
// Directed bench for hex_count_source with DIV=4, DEB_CYCLES=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_hex_count_source;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       btn_pause;
  logic       btn_dir;
  logic [3:0] hex_out;
  logic       dp_out;
  logic       step_tick;
  logic       count_up;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  hex_count_source #(
    .DIV       (4),
    .DEB_CYCLES(3)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .btn_pause(btn_pause),
    .btn_dir  (btn_dir),
    .hex_out  (hex_out),
    .dp_out   (dp_out),
    .step_tick(step_tick),
    .count_up (count_up)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_pause = 1'b1;
    btn_dir   = 1'b1;
    cyc(3);
    chk("rst_hex", 8'(hex_out), 8'h0);
    chk("rst_dp", 8'(dp_out), 8'h0);
    chk("rst_tick", 8'(step_tick), 8'h0);
    chk("rst_up", 8'(count_up), 8'h1);
    rst = 1'b0;

    // 1: free-running count up, step every 4th cycle, wraps F->0
    for (int s = 1; s <= 16; s++) begin
      cyc(3);
      chk("t1_idle", 8'(step_tick), 8'h0);
      cyc(1);
      chk("t1_tick", 8'(step_tick), 8'h1);
      chk("t1_hex", 8'(hex_out), 8'(s % 16));
      chk("t1_dp", 8'(dp_out), 8'h0);
    end

    // 2: direction press; toggles while hex_out=2, then counts down
    cyc(4);
    chk("t2_hex1", 8'(hex_out), 8'h1);
    btn_dir = 1'b0;
    cyc(4);
    chk("t2_hex2", 8'(hex_out), 8'h2);
    chk("t2_up_pre", 8'(count_up), 8'h1);
    cyc(2);
    chk("t2_up_new", 8'(count_up), 8'h0);
    cyc(4);
    chk("t2_hex_1", 8'(hex_out), 8'h1);
    btn_dir = 1'b1;
    cyc(2);
    chk("t2_hex_0", 8'(hex_out), 8'h0);
    chk("t2_tick0", 8'(step_tick), 8'h1);
    cyc(4);
    chk("t2_hex_f", 8'(hex_out), 8'hf);
    cyc(4);
    chk("t2_hex_e", 8'(hex_out), 8'he);
    chk("t2_one_toggle", 8'(count_up), 8'h0);

    // 3: short glitch ignored, then a real pause press
    btn_pause = 1'b0;
    cyc(2);
    btn_pause = 1'b1;
    cyc(2);
    chk("t3_glitch_hex", 8'(hex_out), 8'hd);
    chk("t3_glitch_dp", 8'(dp_out), 8'h0);
    cyc(4);
    chk("t3_hex_c", 8'(hex_out), 8'hc);
    chk("t3_dp_run", 8'(dp_out), 8'h0);
    btn_pause = 1'b0;
    cyc(4);
    chk("t3_hex_b", 8'(hex_out), 8'hb);
    cyc(2);
    chk("t3_dp_hold", 8'(dp_out), 8'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) btn_pause = 1'b1;
      cyc(1);
      chk("t3_frozen_tick", 8'(step_tick), 8'h0);
      chk("t3_frozen_hex", 8'(hex_out), 8'hb);
    end
    chk("t3_dp_kept", 8'(dp_out), 8'h1);

    // 4: resume; first step after the 2 remaining prescaler cycles
    btn_pause = 1'b0;
    cyc(6);
    chk("t4_dp_run", 8'(dp_out), 8'h0);
    chk("t4_hex", 8'(hex_out), 8'hb);
    cyc(1);
    chk("t4_no_tick", 8'(step_tick), 8'h0);
    cyc(1);
    chk("t4_tick", 8'(step_tick), 8'h1);
    chk("t4_hex_a", 8'(hex_out), 8'ha);

    // 5: back to up, then a direction press landing on a step
    btn_pause = 1'b1;
    btn_dir   = 1'b0;
    cyc(4);
    chk("t5_hex_9", 8'(hex_out), 8'h9);
    cyc(2);
    chk("t5_up", 8'(count_up), 8'h1);
    cyc(6);
    chk("t5_hex_b", 8'(hex_out), 8'hb);
    btn_dir = 1'b1;
    cyc(36);
    chk("t5_hex_4", 8'(hex_out), 8'h4);
    cyc(2);
    btn_dir = 1'b0;
    cyc(2);
    chk("t5_hex_5", 8'(hex_out), 8'h5);
    chk("t5_up5", 8'(count_up), 8'h1);
    cyc(4);
    chk("t5_tick6", 8'(step_tick), 8'h1);
    chk("t5_hex_6", 8'(hex_out), 8'h6);
    chk("t5_down", 8'(count_up), 8'h0);
    cyc(4);
    chk("t5_back_5", 8'(hex_out), 8'h5);
    btn_dir = 1'b1;

    // 6: reset while held at 9 counting down; pause button held through reset
    cyc(44);
    chk("t6_hex_a", 8'(hex_out), 8'ha);
    btn_pause = 1'b0;
    cyc(4);
    chk("t6_hex_9", 8'(hex_out), 8'h9);
    cyc(2);
    chk("t6_hold", 8'(dp_out), 8'h1);
    cyc(4);
    chk("t6_hex_hold", 8'(hex_out), 8'h9);
    chk("t6_down", 8'(count_up), 8'h0);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_hex", 8'(hex_out), 8'h0);
    chk("t6_rst_dp", 8'(dp_out), 8'h0);
    chk("t6_rst_up", 8'(count_up), 8'h1);
    chk("t6_rst_tick", 8'(step_tick), 8'h0);
    rst = 1'b0;
    cyc(4);
    chk("t6_post_hex", 8'(hex_out), 8'h1);
    chk("t6_post_dp", 8'(dp_out), 8'h0);
    cyc(1);
    chk("t6_dp_late", 8'(dp_out), 8'h0);
    cyc(1);
    chk("t6_held_press", 8'(dp_out), 8'h1);
    btn_pause = 1'b1;
    cyc(10);
    chk("t6_release", 8'(dp_out), 8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
